// File: rtl/color_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : color_detect_pkg
// Brief    : Filter/colour encodings and FSM types for color_detect_seq.
// Revision : 1.0
// ============================================================================
package color_detect_pkg;

  localparam logic [1:0] RED_FILTER   = 2'd0;
  localparam logic [1:0] BLUE_FILTER  = 2'd1;
  localparam logic [1:0] CLEAR_FILTER = 2'd2;
  localparam logic [1:0] GREEN_FILTER = 2'd3;

  localparam logic [1:0] NONE_COLOR  = 2'd0;
  localparam logic [1:0] RED_COLOR   = 2'd1;
  localparam logic [1:0] GREEN_COLOR = 2'd2;
  localparam logic [1:0] BLUE_COLOR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DECIDE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CH_G = 2'd0,
    CH_R = 2'd1,
    CH_B = 2'd2
  } chan_e;

endpackage
`default_nettype wire

// File: rtl/color_detect_seq_edge_sync_counter.sv
`default_nettype none
// ============================================================================
// Module   : edge_sync_counter
// Brief    : Synchronises an async pulse train, detects rising edges and
//            accumulates them in a saturating counter with clear and enable.
// Revision : 1.0
// ============================================================================
module edge_sync_counter #(
  parameter int CNT_W = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sig_i,
  input  logic             clr_i,
  input  logic             cnt_en_i,
  output logic [CNT_W-1:0] acc_o
);

  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             edge_w;

  assign edge_w = sync_q[1] & ~sync_q[2];

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_en_i && edge_w && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[1:0], sig_i};
      cnt_q  <= clr_i ? '0 : cnt_d;
    end
  end

  // Includes the edge of the current cycle so the window's last cycle counts.
  assign acc_o = cnt_d;

endmodule
`default_nettype wire

// File: rtl/color_detect_seq.sv
`default_nettype none
// ============================================================================
// Module   : color_detect_seq
// Brief    : Sequences sensor filters G->R->B, counts cs_out edges per window
//            and reports the dominant colour with a valid pulse.
// Revision : 1.0
// ============================================================================
module color_detect_seq
  import color_detect_pkg::*;
#(
  parameter int WINDOW_CYCLES = 500,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 9,
  parameter int MIN_COUNT     = 4
) (
  input  logic             clk_1MHz,
  input  logic             rst,
  input  logic             enable,
  input  logic             cs_out,
  output logic [1:0]       filter,
  output logic [1:0]       color,
  output logic             color_valid,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt
);

  localparam int c_tmr_max = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int c_tmr_w   = (c_tmr_max > 1) ? $clog2(c_tmr_max) : 1;
  localparam logic [c_tmr_w-1:0] c_settle_last = c_tmr_w'(SETTLE_CYCLES - 1);
  localparam logic [c_tmr_w-1:0] c_window_last = c_tmr_w'(WINDOW_CYCLES - 1);

  state_e               state_q, state_d;
  chan_e                ch_q, ch_d;
  logic [c_tmr_w-1:0]   tmr_q, tmr_d;
  logic [1:0]           filter_q, filter_d;
  logic [CNT_W-1:0]     red_st_q, red_st_d, grn_st_q, grn_st_d, blu_st_q, blu_st_d;
  logic [CNT_W-1:0]     red_cnt_q, red_cnt_d, grn_cnt_q, grn_cnt_d, blu_cnt_q, blu_cnt_d;
  logic [1:0]           color_q, color_d;
  logic                 valid_q, valid_d;
  logic [CNT_W-1:0]     acc_w;

  edge_sync_counter #(.CNT_W(CNT_W)) u_edge_cnt (
    .clk_i    (clk_1MHz),
    .rst_i    (rst),
    .sig_i    (cs_out),
    .clr_i    (state_q != ST_MEASURE),
    .cnt_en_i (state_q == ST_MEASURE),
    .acc_o    (acc_w)
  );

  // Strictly greatest channel wins; ties or a weak maximum report no colour.
  function automatic logic [1:0] pick_color(input logic [CNT_W-1:0] r,
                                            input logic [CNT_W-1:0] g,
                                            input logic [CNT_W-1:0] b);
    logic [1:0]       c;
    logic [CNT_W-1:0] m;
    c = NONE_COLOR;
    m = '0;
    if (r > g && r > b) begin
      c = RED_COLOR;
      m = r;
    end else if (g > r && g > b) begin
      c = GREEN_COLOR;
      m = g;
    end else if (b > r && b > g) begin
      c = BLUE_COLOR;
      m = b;
    end
    if (32'(m) < 32'(MIN_COUNT)) c = NONE_COLOR;
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    tmr_d     = tmr_q;
    filter_d  = filter_q;
    red_st_d  = red_st_q;
    grn_st_d  = grn_st_q;
    blu_st_d  = blu_st_q;
    red_cnt_d = red_cnt_q;
    grn_cnt_d = grn_cnt_q;
    blu_cnt_d = blu_cnt_q;
    color_d   = color_q;
    valid_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        filter_d = CLEAR_FILTER;
        if (enable) begin
          state_d  = ST_SETTLE;
          ch_d     = CH_G;
          tmr_d    = '0;
          filter_d = GREEN_FILTER;
        end
      end
      ST_SETTLE: begin
        if (tmr_q == c_settle_last) begin
          state_d = ST_MEASURE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + c_tmr_w'(1);
        end
      end
      ST_MEASURE: begin
        if (tmr_q == c_window_last) begin
          tmr_d   = '0;
          state_d = ST_SETTLE;
          unique case (ch_q)
            CH_G: begin
              grn_st_d = acc_w;
              ch_d     = CH_R;
              filter_d = RED_FILTER;
            end
            CH_R: begin
              red_st_d = acc_w;
              ch_d     = CH_B;
              filter_d = BLUE_FILTER;
            end
            default: begin
              blu_st_d = acc_w;
              state_d  = ST_DECIDE;
              filter_d = CLEAR_FILTER;
            end
          endcase
        end else begin
          tmr_d = tmr_q + c_tmr_w'(1);
        end
      end
      default: begin
        red_cnt_d = red_st_q;
        grn_cnt_d = grn_st_q;
        blu_cnt_d = blu_st_q;
        color_d   = pick_color(red_st_q, grn_st_q, blu_st_q);
        valid_d   = 1'b1;
        tmr_d     = '0;
        ch_d      = CH_G;
        if (enable) begin
          state_d  = ST_SETTLE;
          filter_d = GREEN_FILTER;
        end else begin
          state_d  = ST_IDLE;
          filter_d = CLEAR_FILTER;
        end
      end
    endcase
  end

  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ch_q      <= CH_G;
      tmr_q     <= '0;
      filter_q  <= CLEAR_FILTER;
      red_st_q  <= '0;
      grn_st_q  <= '0;
      blu_st_q  <= '0;
      red_cnt_q <= '0;
      grn_cnt_q <= '0;
      blu_cnt_q <= '0;
      color_q   <= NONE_COLOR;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      tmr_q     <= tmr_d;
      filter_q  <= filter_d;
      red_st_q  <= red_st_d;
      grn_st_q  <= grn_st_d;
      blu_st_q  <= blu_st_d;
      red_cnt_q <= red_cnt_d;
      grn_cnt_q <= grn_cnt_d;
      blu_cnt_q <= blu_cnt_d;
      color_q   <= color_d;
      valid_q   <= valid_d;
    end
  end

  assign filter      = filter_q;
  assign color       = color_q;
  assign color_valid = valid_q;
  assign red_cnt     = red_cnt_q;
  assign green_cnt   = grn_cnt_q;
  assign blue_cnt    = blu_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_color_detect_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_color_detect_seq
// Brief    : Randomised scoreboard bench for color_detect_seq against a
//            frame-timeline reference model.
// Revision : 1.0
// ============================================================================
module tb_color_detect_seq;
  import color_detect_pkg::*;

  localparam int W       = 100;
  localparam int S       = 4;
  localparam int CW      = 4;
  localparam int MINC    = 4;
  localparam int SEG     = S + W;
  localparam int DEC_POS = 3 * SEG;
  localparam int SAT     = (1 << CW) - 1;
  localparam int MAXCYC  = 65536;

  logic          clk_1MHz = 1'b0;
  logic          rst      = 1'b1;
  logic          enable   = 1'b0;
  logic          cs_out   = 1'b0;
  logic [1:0]    filter;
  logic [1:0]    color;
  logic          color_valid;
  logic [CW-1:0] red_cnt, green_cnt, blue_cnt;

  color_detect_seq #(
    .WINDOW_CYCLES (W),
    .SETTLE_CYCLES (S),
    .CNT_W         (CW),
    .MIN_COUNT     (MINC)
  ) dut (
    .clk_1MHz    (clk_1MHz),
    .rst         (rst),
    .enable      (enable),
    .cs_out      (cs_out),
    .filter      (filter),
    .color       (color),
    .color_valid (color_valid),
    .red_cnt     (red_cnt),
    .green_cnt   (green_cnt),
    .blue_cnt    (blue_cnt)
  );

  always #5 clk_1MHz = ~clk_1MHz;

  typedef struct packed {
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
    logic [1:0]    color;
  } res_t;

  typedef struct {
    res_t res;
    int   cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   armed    = 1'b0;

  // Reference model state: position within the frame (-1 = idle).
  int   pos       = -1;
  int   acc [3]   = '{0, 0, 0};
  res_t hold      = '0;
  bit   exp_valid = 1'b0;
  bit   samp [MAXCYC];
  int   per [4]   = '{0, 0, 0, 0};

  always @(posedge clk_1MHz) cyc <= cyc + 1;

  function automatic logic [1:0] exp_filter(input int p);
    if (p < 0)        return CLEAR_FILTER;
    if (p < SEG)      return GREEN_FILTER;
    if (p < 2 * SEG)  return RED_FILTER;
    if (p < 3 * SEG)  return BLUE_FILTER;
    return CLEAR_FILTER;
  endfunction

  // Sensor: square wave of the period assigned to the selected filter.
  function automatic logic sensor(input logic [1:0] f, input int k);
    int p;
    p = per[f];
    if (p < 0)  return 1'($urandom_range(0, 1));
    if (p == 0) return 1'b0;
    return ((k % p) < (p / 2));
  endfunction

  function automatic res_t decide(input int g, input int r, input int b);
    res_t o;
    int   mx;
    int   nmax;
    mx = g;
    if (r > mx) mx = r;
    if (b > mx) mx = b;
    nmax = int'(g == mx) + int'(r == mx) + int'(b == mx);
    o.r = CW'(r);
    o.g = CW'(g);
    o.b = CW'(b);
    if (nmax != 1 || mx < MINC) o.color = NONE_COLOR;
    else if (r == mx)           o.color = RED_COLOR;
    else if (g == mx)           o.color = GREEN_COLOR;
    else                        o.color = BLUE_COLOR;
    return o;
  endfunction

  task automatic set_periods(input int g, input int r, input int b);
    per[GREEN_FILTER] = g;
    per[RED_FILTER]   = r;
    per[BLUE_FILTER]  = b;
    per[CLEAR_FILTER] = 0;
  endtask

  function automatic int rand_per();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return -1;
      default: return int'($urandom_range(2, 30));
    endcase
  endfunction

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic tick(input logic r, input logic en);
    int         k;
    logic       v;
    logic [1:0] fexp;
    logic [2+1+$bits(res_t)-1:0] got_v, exp_v;
    @(negedge clk_1MHz);
    k    = cyc;
    fexp = exp_filter(pos);
    if (armed) begin
      got_v = {filter, color_valid, red_cnt, green_cnt, blue_cnt, color};
      exp_v = {fexp, exp_valid, hold};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d filter/valid/r/g/b/color got=%h expected=%h", k, got_v, exp_v);
      end
    end
    v      = sensor(fexp, k);
    rst    = r;
    enable = en;
    cs_out = v;
    samp[k] = v;

    if (pos >= 0 && pos < DEC_POS && (pos % SEG) >= S && k >= 3) begin
      if (samp[k-2] && !samp[k-3]) begin
        acc[pos / SEG] = (acc[pos / SEG] + 1 > SAT) ? SAT : acc[pos / SEG] + 1;
      end
    end

    exp_valid = 1'b0;
    if (r) begin
      pos  = -1;
      acc  = '{0, 0, 0};
      hold = '0;
      samp[k] = 1'b0;
      if (k >= 1) samp[k-1] = 1'b0;
      if (k >= 2) samp[k-2] = 1'b0;
    end else if (pos == DEC_POS) begin
      exp_t e;
      hold      = decide(acc[0], acc[1], acc[2]);
      exp_valid = 1'b1;
      e.res     = hold;
      e.cyc     = k + 1;
      sb_q.push_back(e);
      acc = '{0, 0, 0};
      pos = en ? 0 : -1;
    end else if (pos < 0) begin
      if (en) begin
        pos = 0;
        acc = '{0, 0, 0};
      end
    end else begin
      pos++;
    end
  endtask

  // Monitor: every valid pulse must match the oldest predicted result.
  always @(negedge clk_1MHz) begin
    if (armed && color_valid === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid cyc=%0d got r/g/b/color=%h expected no report", cyc,
                 {red_cnt, green_cnt, blue_cnt, color});
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({red_cnt, green_cnt, blue_cnt, color} !== e.res || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL report cyc=%0d got r/g/b/color=%h expected=%h at cyc=%0d", cyc,
                   {red_cnt, green_cnt, blue_cnt, color}, e.res, e.cyc);
        end
      end
    end
  end

  initial begin
    // Reset, then long idle with a noisy sensor.
    set_periods(-1, -1, -1);
    repeat (3) tick(1'b1, 1'b0);
    armed = 1'b1;
    repeat (1000) tick(1'b0, 1'b0);

    // Red dominant.
    set_periods(25, 10, 25);
    repeat (3 * 313) tick(1'b0, 1'b1);
    // Equal periods: tie.
    set_periods(20, 20, 20);
    repeat (2 * 313) tick(1'b0, 1'b1);
    // Held low: all zero.
    set_periods(0, 0, 0);
    repeat (313) tick(1'b0, 1'b1);
    // Noise floor boundary: ~3 edges (below) then exactly 4 (at threshold).
    set_periods(0, 34, 0);
    repeat (313) tick(1'b0, 1'b1);
    set_periods(0, 25, 0);
    repeat (313) tick(1'b0, 1'b1);
    // Blue saturates.
    set_periods(25, 25, 2);
    repeat (2 * 313) tick(1'b0, 1'b1);
    repeat (320) tick(1'b0, 1'b0);

    // Reset mid-frame.
    set_periods(10, 10, 10);
    repeat (150) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    repeat (400) tick(1'b0, 1'b0);

    // Enable dropped early in the frame.
    set_periods(25, 2, 25);
    repeat (50) tick(1'b0, 1'b1);
    repeat (450) tick(1'b0, 1'b0);

    // Randomised runs.
    for (int it = 0; it < 20; it++) begin
      int   len;
      logic en;
      set_periods(rand_per(), rand_per(), rand_per());
      len = int'($urandom_range(50, 700));
      en  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < len; i++) tick(($urandom_range(0, 999) == 0), en);
    end

    repeat (400) tick(1'b0, 1'b0);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_reports got %0d outstanding expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
